// File: rtl/div_sequencer_if.sv
// Divide request/response bundle between the core datapath and the divide sequencer.
// Latency: none, plain wires.
// Backpressure: the sequencer's Stall output throttles the core; Start is held by the core while stalled.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Signed;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Stall;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;

  // Core side: issues the request and watches the status.
  modport master (
    output Start, Signed, SrcA, SrcB,
    input  Stall, Busy, Done, Result
  );

  // Sequencer side.
  modport slave (
    input  Start, Signed, SrcA, SrcB,
    output Stall, Busy, Done, Result
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative restoring divider sequencer for sdiv/udiv; quotient only, remainder dropped.
// Latency: WIDTH+2 cycles from Start to the Done pulse (1 cycle on a zero divisor).
// Backpressure: Stall freezes the core from the request cycle until the Done cycle.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  div_sequencer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    cnt;
  logic             neg_q;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             div_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             trial_ok;

  // Operand magnitudes and one restoring step. The trial difference fits in
  // WIDTH bits whenever it is kept, since the partial remainder stays below the divisor.
  always_comb begin
    mag_a    = (bus.Signed && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
    mag_b    = (bus.Signed && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;
    div_zero = (bus.SrcB == '0);
    shifted  = {rem, quo[WIDTH-1]};
    trial_ok = (shifted >= {1'b0, div_mag});
    trial    = shifted[WIDTH-1:0] - div_mag;
  end

  // State register; reset drops straight to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs. Stall is gated by reset so it also drops
  // immediately while reset is held even if the core keeps Start high.
  always_comb begin
    state_nxt = state;
    bus.Stall = 1'b0;
    bus.Busy  = (state != IDLE);
    bus.Done  = (state == DONE);
    case (state)
      IDLE: begin
        bus.Stall = bus.Start & reset;
        if (bus.Start) begin
          state_nxt = div_zero ? DONE : RUN;
        end
      end
      RUN: begin
        bus.Stall = 1'b1;
        if (cnt == LAST) begin
          state_nxt = FIXUP;
        end
      end
      FIXUP: begin
        bus.Stall = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        // Start is typically still high here; it must not relaunch.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, shift/subtract iterations and sign fixup.
  // Operands are only ever read from the latched copies after the Start cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem     <= '0;
      quo     <= '0;
      div_mag <= '0;
      neg_q   <= 1'b0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            div_mag <= mag_b;
            neg_q   <= bus.Signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
            rem     <= '0;
            quo     <= mag_a;
            cnt     <= '0;
            if (div_zero) begin
              result <= '0;
            end
          end
        end
        RUN: begin
          rem <= trial_ok ? trial : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], trial_ok};
          cnt <= cnt + CW'(1);
        end
        FIXUP: begin
          // Negation wraps, so most-negative / -1 yields most-negative.
          result <= neg_q ? -quo : quo;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Result = result;

endmodule
